// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern source feeding the VGA output stage.
// Two-stage pixel pipeline (decode, then colour mux with blanking); syncs and
// display-active are delayed to match. Pattern selection is latched on the
// rising edge of Vsync. Define VGA_PATGEN_NOISE_EN to build the LFSR noise
// pattern (mode 7); without it mode 7 is flat mid-grey.
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned BAR_W     = 80,
  parameter int unsigned CHK_SHIFT = 5,
  parameter int unsigned MBAR_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] Xpos,
  input  logic [11:0] Ypos,
  input  logic        disp_activ,
  input  logic        Hsync,
  input  logic        Vsync,
  input  logic [3:0]  mode,
  output logic [7:0]  R_o,
  output logic [7:0]  G_o,
  output logic [7:0]  B_o,
  output logic        Hsync_o,
  output logic        Vsync_o,
  output logic        disp_activ_o,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned NUM_BARS = 8;

  // frame tracking
  logic       vs_q;
  logic [3:0] mode_q;
  logic       frame_edge_c;

  // stage-1 decode results
  logic [3:0] s1_mode;
  logic [2:0] s1_bar_idx;
  logic       s1_chk;
  logic       s1_hit;
  logic [7:0] s1_hramp;
  logic [7:0] s1_vramp;
  logic       s1_de;
  logic       s1_hs;
  logic       s1_vs;

  // combinational decode
  logic [2:0]  bar_idx_c;
  logic [11:0] bx_c;
  logic        hit_c;
  logic [23:0] pix_c;

  // row bits below the ramp slice and above the visible range are not needed
  logic unused_ok;
  assign unused_ok = ^{Ypos[11:10], Ypos[1:0], 32'(H_ACTIVE)};

  assign frame_edge_c = Vsync & ~vs_q;

  // Vsync edge detect, mode latch and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q      <= 1'b0;
      mode_q    <= 4'd0;
      frame_cnt <= 8'd0;
    end else begin
      vs_q <= Vsync;
      if (frame_edge_c) begin
        mode_q    <= mode;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // bar index by comparator chain; saturates at the last bar
  always_comb begin
    bar_idx_c = 3'd0;
    for (int i = 1; i < NUM_BARS; i++) begin
      if (32'(Xpos) >= 32'(i) * BAR_W) bar_idx_c = bar_idx_c + 3'd1;
    end
  end

  // moving bar hit test at 12 bits so bx + width never wraps
  always_comb begin
    bx_c  = {3'b000, frame_cnt, 1'b0};
    hit_c = (Xpos >= bx_c) && (Xpos < bx_c + 12'(MBAR_W));
  end

`ifdef VGA_PATGEN_NOISE_EN
  logic [15:0] lfsr;
  logic [15:0] s1_noise;

  // Galois LFSR, advances once per active pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (disp_activ) begin
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    end
  end

  // noise sample travels with the stage-1 decode
  always_ff @(posedge clk) begin
    if (rst) s1_noise <= 16'd0;
    else     s1_noise <= lfsr;
  end
`endif

  // stage 1: pattern decode and aligned control
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_mode    <= 4'd0;
      s1_bar_idx <= 3'd0;
      s1_chk     <= 1'b0;
      s1_hit     <= 1'b0;
      s1_hramp   <= 8'd0;
      s1_vramp   <= 8'd0;
      s1_de      <= 1'b0;
      s1_hs      <= 1'b0;
      s1_vs      <= 1'b0;
    end else begin
      s1_mode    <= mode_q;
      s1_bar_idx <= bar_idx_c;
      s1_chk     <= Xpos[CHK_SHIFT] ^ Ypos[CHK_SHIFT];
      s1_hit     <= hit_c;
      s1_hramp   <= Xpos[9:2];
      s1_vramp   <= Ypos[9:2];
      s1_de      <= disp_activ;
      s1_hs      <= Hsync;
      s1_vs      <= Vsync;
    end
  end

  // colour selection from decoded fields
  always_comb begin
    pix_c = 24'h000000;
    case (s1_mode)
      4'd1: pix_c = 24'hFFFFFF;
      4'd2: begin
        case (s1_bar_idx)
          3'd0: pix_c = 24'hFFFFFF;
          3'd1: pix_c = 24'hFFFF00;
          3'd2: pix_c = 24'h00FFFF;
          3'd3: pix_c = 24'h00FF00;
          3'd4: pix_c = 24'hFF00FF;
          3'd5: pix_c = 24'hFF0000;
          3'd6: pix_c = 24'h0000FF;
          3'd7: pix_c = 24'h000000;
        endcase
      end
      4'd3: pix_c = s1_chk ? 24'hFFFFFF : 24'h000000;
      4'd4: pix_c = {s1_hramp, s1_hramp, s1_hramp};
      4'd5: pix_c = {s1_vramp, s1_vramp, s1_vramp};
      4'd6: pix_c = s1_hit ? 24'hFFFFFF : 24'h000080;
`ifdef VGA_PATGEN_NOISE_EN
      4'd7: pix_c = {s1_noise[15:8], s1_noise[7:0], s1_noise[15:8] ^ s1_noise[7:0]};
`else
      4'd7: pix_c = 24'h808080;
`endif
      default: pix_c = 24'h000000;
    endcase
  end

  // stage 2: blanking and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      R_o          <= 8'd0;
      G_o          <= 8'd0;
      B_o          <= 8'd0;
      Hsync_o      <= 1'b0;
      Vsync_o      <= 1'b0;
      disp_activ_o <= 1'b0;
    end else begin
      R_o          <= s1_de ? pix_c[23:16] : 8'd0;
      G_o          <= s1_de ? pix_c[15:8]  : 8'd0;
      B_o          <= s1_de ? pix_c[7:0]   : 8'd0;
      Hsync_o      <= s1_hs;
      Vsync_o      <= s1_vs;
      disp_activ_o <= s1_de;
    end
  end

endmodule
